// File: rtl/err_inj_ctrl.sv
// rtl/err_inj_ctrl.sv - frame error-injection controller (one-shot / periodic parity and framing errors)
module err_inj_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_mode,
   input  logic [1:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic             frame_start,
   input  logic             frame_done,
   input  logic             clr_cnt,
   output logic             gen_par_err,
   output logic             gen_frt_err,
   output logic             busy,
   output logic [CNT_W-1:0] inj_cnt
);

   typedef enum logic [1:0] {IDLE, ARMED, INJECT} state_t;

   localparam logic [1:0]       MODE_ONE = 2'b01;
   localparam logic [1:0]       MODE_PER = 2'b10;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [1:0]       mode_q, sel_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0] inj_cnt_q;
   logic             par_q, par_d, frt_q, frt_d;
   logic             inc;
   logic [CNT_W-1:0] eff_period;
   logic             last_frame;

   // A programmed period of 0 behaves exactly like a period of 1.
   assign eff_period = (period_q == '0) ? CNT_ONE : period_q;
   assign last_frame = (fcnt_q == eff_period - CNT_ONE);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      par_d   = par_q;
      frt_d   = frt_q;
      inc     = 1'b0;
      if (cfg_we) begin
         fcnt_d  = '0;
         par_d   = 1'b0;
         frt_d   = 1'b0;
         state_d = (cfg_mode == MODE_ONE || cfg_mode == MODE_PER) ? ARMED : IDLE;
      end else begin
         case (state_q)
            ARMED: begin
               if (frame_start) begin
                  if (mode_q == MODE_PER && !last_frame) begin
                     fcnt_d = fcnt_q + CNT_ONE;
                  end else begin
                     fcnt_d  = '0;
                     par_d   = sel_q[0];
                     frt_d   = sel_q[1];
                     state_d = INJECT;
                  end
               end
            end
            INJECT: begin
               // A frame_start on the closing edge is dropped; the next one is the candidate.
               if (frame_done) begin
                  par_d   = 1'b0;
                  frt_d   = 1'b0;
                  inc     = 1'b1;
                  state_d = (mode_q == MODE_PER) ? ARMED : IDLE;
               end
            end
            default: begin
               par_d = 1'b0;
               frt_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mode_q    <= 2'b00;
         sel_q     <= 2'b00;
         period_q  <= '0;
         fcnt_q    <= '0;
         par_q     <= 1'b0;
         frt_q     <= 1'b0;
         inj_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         par_q   <= par_d;
         frt_q   <= frt_d;
         if (cfg_we) begin
            mode_q   <= cfg_mode;
            sel_q    <= cfg_sel;
            period_q <= cfg_period;
         end
         if (clr_cnt) begin
            inj_cnt_q <= inc ? CNT_ONE : '0;
         end else if (inc && inj_cnt_q != CNT_MAX) begin
            inj_cnt_q <= inj_cnt_q + CNT_ONE;
         end
      end
   end

   assign gen_par_err = par_q;
   assign gen_frt_err = frt_q;
   assign busy        = (state_q == INJECT);
   assign inj_cnt     = inj_cnt_q;

endmodule

// File: tb/tb_err_inj_ctrl.sv
// tb/tb_err_inj_ctrl.sv - directed vector bench for err_inj_ctrl
module tb_err_inj_ctrl;

   typedef struct {
      logic       we;
      logic [1:0] mode;
      logic [1:0] sel;
      logic [7:0] per;
      logic       fs;
      logic       fd;
      logic       clr;
      logic       par;
      logic       frt;
      logic       bsy;
      logic [7:0] cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_mode = 2'b00;
   logic [1:0] cfg_sel = 2'b00;
   logic [7:0] cfg_period = 8'd0;
   logic       frame_start = 1'b0;
   logic       frame_done = 1'b0;
   logic       clr_cnt = 1'b0;
   logic       gen_par_err, gen_frt_err, busy;
   logic [7:0] inj_cnt;
   logic       gen_par_err2, gen_frt_err2, busy2;
   logic [1:0] inj_cnt2;

   int         checks = 0;
   int         errors = 0;
   vec_t       vecs[$];
   logic [7:0] exp_cnt;

   always #5 clk = ~clk;

   err_inj_ctrl #(.CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
      .cfg_period(cfg_period), .frame_start(frame_start), .frame_done(frame_done),
      .clr_cnt(clr_cnt), .gen_par_err(gen_par_err), .gen_frt_err(gen_frt_err),
      .busy(busy), .inj_cnt(inj_cnt)
   );

   err_inj_ctrl #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
      .cfg_period(cfg_period[1:0]), .frame_start(frame_start), .frame_done(frame_done),
      .clr_cnt(clr_cnt), .gen_par_err(gen_par_err2), .gen_frt_err(gen_frt_err2),
      .busy(busy2), .inj_cnt(inj_cnt2)
   );

   function automatic vec_t mk(input logic we, input logic [1:0] mode, input logic [1:0] sel,
                               input logic [7:0] per, input logic fs, input logic fd,
                               input logic clr, input logic par, input logic frt,
                               input logic bsy, input logic [7:0] cnt);
      vec_t v;
      v.we = we; v.mode = mode; v.sel = sel; v.per = per;
      v.fs = fs; v.fd = fd; v.clr = clr;
      v.par = par; v.frt = frt; v.bsy = bsy; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      cfg_we = v.we; cfg_mode = v.mode; cfg_sel = v.sel; cfg_period = v.per;
      frame_start = v.fs; frame_done = v.fd; clr_cnt = v.clr;
      @(posedge clk);
      #1;
      chk("gen_par_err", idx, {7'd0, gen_par_err}, {7'd0, v.par});
      chk("gen_frt_err", idx, {7'd0, gen_frt_err}, {7'd0, v.frt});
      chk("busy", idx, {7'd0, busy}, {7'd0, v.bsy});
      chk("inj_cnt", idx, inj_cnt, v.cnt);
   endtask

   // Each frame: start, one mid-frame cycle, done. Mid-frame start pulses only on injecting frames.
   task automatic add_frames(input int n, input int per, input logic [1:0] sel, input logic last_fs);
      int   eff;
      logic inj;
      eff = (per == 0) ? 1 : per;
      for (int k = 1; k <= n; k++) begin
         inj = ((k % eff) == 0);
         vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, inj & sel[0], inj & sel[1], inj, exp_cnt));
         vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, inj, 1'b0, 1'b0, inj & sel[0], inj & sel[1], inj, exp_cnt));
         if (inj) exp_cnt = exp_cnt + 8'd1;
         vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, last_fs && (k == n), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt));
      end
   endtask

   initial begin
      // One-shot parity
      exp_cnt = 8'd0;
      vecs.push_back(mk(1'b1, 2'd1, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
      // Periodic framing, period 3, counter cleared with the config write
      vecs.push_back(mk(1'b1, 2'd2, 2'd2, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
      exp_cnt = 8'd0;
      add_frames(9, 3, 2'd2, 1'b0);
      // Period 0 behaves as period 1
      vecs.push_back(mk(1'b1, 2'd2, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
      exp_cnt = 8'd0;
      add_frames(4, 0, 2'd3, 1'b0);
      // Period 1; last done coincides with a start that must be dropped
      vecs.push_back(mk(1'b1, 2'd2, 2'd3, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
      exp_cnt = 8'd0;
      add_frames(4, 1, 2'd3, 1'b1);
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4));
      add_frames(1, 1, 2'd3, 1'b0);
      // Mid-frame abort
      vecs.push_back(mk(1'b1, 2'd1, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0));
      vecs.push_back(mk(1'b1, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      vecs.push_back(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));

      // Reset state, held across edges
      repeat (2) @(posedge clk);
      #1;
      chk("rst_par", 0, {7'd0, gen_par_err}, 8'd0);
      chk("rst_frt", 0, {7'd0, gen_frt_err}, 8'd0);
      chk("rst_busy", 0, {7'd0, busy}, 8'd0);
      chk("rst_cnt", 0, inj_cnt, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // Out of reset: a frame start without configuration does nothing
      apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0), 0);

      foreach (vecs[i]) apply(vecs[i], i + 1);

      // Saturation on the 2-bit instance, then clear coinciding with a completed injection
      apply(mk(1'b1, 2'd2, 2'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0), 200);
      for (int i = 0; i < 5; i++) begin
         apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'(i)), 201 + 2 * i);
         apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i + 1)), 202 + 2 * i);
         chk("sat_cnt", i, {6'd0, inj_cnt2}, (i >= 2) ? 8'd3 : 8'(i + 1));
      end
      apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5), 220);
      apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1), 221);
      chk("clr_inc_cnt2", 221, {6'd0, inj_cnt2}, 8'd1);

      // Asynchronous reset between edges during an injection
      apply(mk(1'b1, 2'd1, 2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1), 300);
      apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1), 301);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_par", 302, {7'd0, gen_par_err}, 8'd0);
      chk("arst_frt", 302, {7'd0, gen_frt_err}, 8'd0);
      chk("arst_busy", 302, {7'd0, busy}, 8'd0);
      chk("arst_cnt", 302, inj_cnt, 8'd0);
      chk("arst_cnt2", 302, {6'd0, inj_cnt2}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0), 303);
      apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0), 304);
      apply(mk(1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0), 305);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/err_inj_ctrl.md
ERR_INJ_CTRL -- requirements
Module: err_inj_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of the period register, frame counter and injection counter.
REQ-002 CLK  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 CFG_WE  input  1  single-cycle pulse that loads CFG_MODE, CFG_SEL and CFG_PERIOD.
REQ-005 CFG_MODE  input  2  injection mode: 00 off, 01 one-shot, 10 periodic, 11 reserved (treated as off).
REQ-006 CFG_SEL  input  2  error select: bit0 parity error, bit1 framing error; both bits may be set.
REQ-007 CFG_PERIOD  input  CNT_W  periodic mode injects on every CFG_PERIOD-th frame; the value 0 is treated as 1.
REQ-008 FRAME_START  input  1  single-cycle pulse marking a new 10-bit frame entering the error-generation datapath.
REQ-009 FRAME_DONE  input  1  single-cycle pulse marking the current frame consumed downstream.
REQ-010 CLR_CNT  input  1  synchronous clear of INJ_CNT.
REQ-011 GEN_PAR_ERR  output  1  registered parity-inversion enable to the error-generation datapath.
REQ-012 GEN_FRT_ERR  output  1  registered stop-bit-inversion enable to the error-generation datapath.
REQ-013 BUSY  output  1  high when the state is INJECT.
REQ-014 INJ_CNT  output  CNT_W  count of completed injected frames; saturates at all-ones.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ARMED and INJECT.
REQ-016 IDLE: GEN_* outputs are 0 and FRAME_START/FRAME_DONE are ignored.
REQ-017 On a CFG_WE cycle, in any state, the block SHALL latch the configuration and clear FCNT (the frame counter), and SHALL go to ARMED if CFG_MODE is 01 or 10, otherwise to IDLE.
REQ-018 CFG_WE SHALL take priority over FRAME_START, FRAME_DONE and CLR_CNT effects on the state and on FCNT.
REQ-019 Both GEN_* outputs SHALL deassert on the edge that applies CFG_WE.
REQ-020 A CFG_WE that aborts INJECT SHALL NOT increment INJ_CNT.
REQ-021 ARMED, one-shot: on FRAME_START, the block SHALL go to INJECT.
REQ-022 ARMED, periodic, FRAME_START with FCNT == effective period - 1: the block SHALL clear FCNT and go to INJECT.
REQ-023 ARMED, periodic, FRAME_START otherwise: the block SHALL increment FCNT and stay in ARMED.
REQ-024 FRAME_DONE SHALL be ignored in ARMED.
REQ-025 Latency: GEN_PAR_ERR = SEL[0] and GEN_FRT_ERR = SEL[1] SHALL be high from the first cycle after the triggering FRAME_START is sampled.
REQ-026 GEN_* SHALL hold constant for the whole INJECT state.
REQ-027 INJECT: FRAME_START SHALL be ignored.
REQ-028 INJECT: on FRAME_DONE, the block SHALL clear GEN_* on the same edge and increment INJ_CNT (saturating).
REQ-029 INJECT exit on FRAME_DONE: the next state SHALL be IDLE in one-shot mode and ARMED in periodic mode.
REQ-030 A FRAME_START coinciding with the FRAME_DONE that ends INJECT SHALL be ignored; the next injection candidate is the next FRAME_START.
REQ-031 A frame skipped in ARMED SHALL never assert GEN_*.
REQ-032 FCNT wrap: FCNT SHALL never exceed effective period - 1.
REQ-033 CLR_CNT SHALL clear INJ_CNT on the next edge.
REQ-034 If CLR_CNT and an INJ_CNT increment occur in the same cycle, INJ_CNT SHALL become 1.
REQ-035 CFG_SEL = 00 SHALL still run the FSM and count injections with GEN_* held at 0.

Reset
REQ-036 RST_N low SHALL immediately force: state IDLE, GEN_PAR_ERR = 0, GEN_FRT_ERR = 0, BUSY = 0, INJ_CNT = 0, FCNT = 0 and latched config = 0 (mode off).
REQ-037 Reset asserted mid-INJECT SHALL clear GEN_* asynchronously and discard the in-flight injection.
REQ-038 After RST_N is released, the block SHALL remain in IDLE until a CFG_WE.

Verification
REQ-039 The bench SHALL cover one-shot: CFG_WE mode=01 sel=01; FRAME_START at t0 -> GEN_PAR_ERR=1 from t0+1; FRAME_DONE at t5 -> GEN_PAR_ERR=0 at t6, INJ_CNT=1, state IDLE; a further FRAME_START produces no injection.
REQ-040 The bench SHALL cover periodic: mode=10 sel=10 period=3, 9 frames -> GEN_FRT_ERR high only during frames 3, 6 and 9; INJ_CNT=3.
REQ-041 The bench SHALL cover period=0 and period=1: mode=10 sel=11, 4 frames -> both GEN_* high on every frame; INJ_CNT=4.
REQ-042 The bench SHALL cover mid-frame abort: CFG_WE mode=00 during INJECT -> GEN_*=0 the next cycle; INJ_CNT unchanged; later FRAME_DONE has no effect.
REQ-043 The bench SHALL cover saturation and clear: CNT_W=2, 5 injections -> INJ_CNT=3; CLR_CNT coinciding with a completing injection -> INJ_CNT=1.
REQ-044 The bench SHALL cover async reset: RST_N low during INJECT, between clock edges -> GEN_*, BUSY and INJ_CNT read 0 before the next edge; FRAME_START after release -> no injection.
